// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register bridge.
package spi_reg_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_PERIOD = 8'h01;
  localparam logic [7:0] ADDR_DUTY0  = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'h0E;
  localparam logic [7:0] ADDR_ID     = 8'h0F;

  localparam logic [7:0] ID_VALUE = 8'hA5;

  localparam logic [1:0] EVENT_IDLE  = 2'b00;
  localparam logic [1:0] EVENT_READ  = 2'b10;
  localparam logic [1:0] EVENT_WRITE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    ACT,
    DONE
  } state_e;

endpackage

// File: rtl/event_sync.sv
// STAGES-deep synchronizer for the 2-bit SPI event bus, synchronous reset to idle.
module event_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] ev_i,
  output logic [1:0] ev_o
);

  logic [1:0] sync_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ev_i;
      for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ev_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI byte-bus to PWM register bank bridge with event qualification and clear-on-read status.
// Optional: define SPI_REG_SHADOW_EN to double-buffer PERIOD/DUTY until period_end_i.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  PERIOD_RST  = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            b_addr_i,
  input  logic [7:0]            b_data_i,
  input  logic [1:0]            b_event_i,
  output logic [7:0]            b_data_o,
  output logic [NUM_CH-1:0]     enable_o,
  output logic [7:0]            period_o,
  output logic [8*NUM_CH-1:0]   duty_o,
  input  logic                  period_end_i
);

  logic [1:0]        ev_sync;
  state_e            state_q;
  logic [1:0]        ev_prev_q;
  logic [NUM_CH-1:0] ctrl_q;
  logic [7:0]        period_q;
  logic [7:0]        duty_q [NUM_CH];
  logic [3:0]        wcnt_q;
  logic              err_q;
  logic              rw_hit;
  logic [7:0]        period_rd;
  logic [7:0]        duty_rd [NUM_CH];

  event_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ev_i  (b_event_i),
    .ev_o  (ev_sync)
  );

`ifdef SPI_REG_SHADOW_EN
  logic [7:0] period_sh_q;
  logic [7:0] duty_sh_q [NUM_CH];
  assign period_rd = period_sh_q;
  assign duty_rd   = duty_sh_q;
`else
  logic unused_period_end;
  assign unused_period_end = period_end_i;
  assign period_rd = period_q;
  assign duty_rd   = duty_q;
`endif

  always_comb begin
    b_data_o = '0;
    rw_hit   = (b_addr_i == ADDR_CTRL) || (b_addr_i == ADDR_PERIOD);
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (b_addr_i == ADDR_DUTY0 + 8'(n)) begin
        rw_hit   = 1'b1;
        b_data_o = duty_rd[n];
      end
    end
    case (b_addr_i)
      ADDR_CTRL:   b_data_o[NUM_CH-1:0] = ctrl_q;
      ADDR_PERIOD: b_data_o = period_rd;
      ADDR_STATUS: b_data_o = {wcnt_q, 3'b000, err_q};
      ADDR_ID:     b_data_o = ID_VALUE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ev_prev_q <= EVENT_IDLE;
      ctrl_q    <= '0;
      period_q  <= PERIOD_RST;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      for (int unsigned n = 0; n < NUM_CH; n++) duty_q[n] <= '0;
`ifdef SPI_REG_SHADOW_EN
      period_sh_q <= PERIOD_RST;
      for (int unsigned n = 0; n < NUM_CH; n++) duty_sh_q[n] <= '0;
`endif
    end else begin
`ifdef SPI_REG_SHADOW_EN
      // Transfer uses the pre-edge shadow, so a write landing this cycle waits for the next wrap.
      if (period_end_i) begin
        period_q <= period_sh_q;
        for (int unsigned n = 0; n < NUM_CH; n++) duty_q[n] <= duty_sh_q[n];
      end
`endif
      case (state_q)
        IDLE: begin
          if (ev_sync != EVENT_IDLE) begin
            ev_prev_q <= ev_sync;
            state_q   <= QUAL;
          end
        end
        QUAL: begin
          if (ev_sync == EVENT_IDLE) state_q <= IDLE;
          else if (ev_sync != ev_prev_q) ev_prev_q <= ev_sync;
          else state_q <= ACT;
        end
        ACT: begin
          state_q <= DONE;
          if (ev_prev_q == EVENT_WRITE) begin
            if (rw_hit) begin
              wcnt_q <= wcnt_q + 4'd1;
              if (b_addr_i == ADDR_CTRL) ctrl_q <= b_data_i[NUM_CH-1:0];
`ifdef SPI_REG_SHADOW_EN
              if (b_addr_i == ADDR_PERIOD) period_sh_q <= b_data_i;
              for (int unsigned n = 0; n < NUM_CH; n++)
                if (b_addr_i == ADDR_DUTY0 + 8'(n)) duty_sh_q[n] <= b_data_i;
`else
              if (b_addr_i == ADDR_PERIOD) period_q <= b_data_i;
              for (int unsigned n = 0; n < NUM_CH; n++)
                if (b_addr_i == ADDR_DUTY0 + 8'(n)) duty_q[n] <= b_data_i;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end else if (ev_prev_q == EVENT_READ && b_addr_i == ADDR_STATUS) begin
            err_q <= 1'b0;
          end
        end
        DONE: begin
          if (ev_sync == EVENT_IDLE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    duty_o = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) duty_o[8*n +: 8] = duty_q[n];
  end

  assign enable_o = ctrl_q;
  assign period_o = period_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge against a transaction-level register model.
module tb_spi_reg_bridge;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
`ifdef SPI_REG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          b_addr, b_data, b_rdata;
  logic [1:0]          b_event;
  logic [NUM_CH-1:0]   enable;
  logic [7:0]          period;
  logic [8*NUM_CH-1:0] duty;
  logic                period_end;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_ctrl, m_period_sh, m_period_out;
  logic [7:0] m_duty_sh [NUM_CH];
  logic [7:0] m_duty_out [NUM_CH];
  int         m_cnt;
  bit         m_err;

  always #5 clk = ~clk;

  spi_reg_bridge #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .PERIOD_RST(8'hFF)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .b_addr_i     (b_addr),
    .b_data_i     (b_data),
    .b_event_i    (b_event),
    .b_data_o     (b_rdata),
    .enable_o     (enable),
    .period_o     (period),
    .duty_o       (duty),
    .period_end_i (period_end)
  );

  task automatic model_reset();
    m_ctrl = 8'h00; m_period_sh = 8'hFF; m_period_out = 8'hFF;
    for (int n = 0; n < NUM_CH; n++) begin m_duty_sh[n] = 8'h00; m_duty_out[n] = 8'h00; end
    m_cnt = 0; m_err = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == 8'h00) return m_ctrl;
    if (a == 8'h01) return m_period_sh;
    if (a == 8'h0E) return {m_cnt[3:0], 3'b000, m_err};
    if (a == 8'h0F) return 8'hA5;
    if (a >= 8'h02 && int'(a) < 2 + NUM_CH) return m_duty_sh[int'(a) - 2];
    return 8'h00;
  endfunction

  task automatic model_apply(input logic [1:0] ev, input logic [7:0] a, input logic [7:0] d);
    if (ev == 2'b11) begin
      if (a == 8'h00) begin m_ctrl = d & 8'((1 << NUM_CH) - 1); m_cnt = (m_cnt + 1) % 16; end
      else if (a == 8'h01) begin m_period_sh = d; m_cnt = (m_cnt + 1) % 16; end
      else if (a >= 8'h02 && int'(a) < 2 + NUM_CH) begin m_duty_sh[int'(a) - 2] = d; m_cnt = (m_cnt + 1) % 16; end
      else m_err = 1'b1;
    end else if (ev == 2'b10 && a == 8'h0E) begin
      m_err = 1'b0;
    end
    if (!SHADOW) begin
      m_period_out = m_period_sh;
      for (int n = 0; n < NUM_CH; n++) m_duty_out[n] = m_duty_sh[n];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; b_event = 2'b00; period_end = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic pulse_period_end();
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    if (SHADOW) begin
      m_period_out = m_period_sh;
      for (int n = 0; n < NUM_CH; n++) m_duty_out[n] = m_duty_sh[n];
    end
  endtask

  // hold == 1 is too short to survive qualification, so the model ignores it.
  task automatic txn(input logic [1:0] ev, input logic [7:0] a, input logic [7:0] d,
                     input int hold, input bit skew);
    @(negedge clk);
    b_addr = a; b_data = d;
    if (skew) begin b_event = 2'b01; @(negedge clk); end
    b_event = ev;
    repeat (hold) @(negedge clk);
    b_event = 2'b00;
    repeat (SYNC + 4) @(negedge clk);
    if (hold > 1) model_apply(ev, a, d);
  endtask

  task automatic test_reset();
    logic [7:0] addrs [5];
    logic [7:0] exp   [5];
    addrs = '{8'h00, 8'h01, 8'h0F, 8'h0E, 8'h20};
    exp   = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b_addr = addrs[i]; #1;
      checks++;
      if (b_rdata !== exp[i]) begin
        errors++; $display("FAIL reset_read addr %h: got %h expected %h", addrs[i], b_rdata, exp[i]);
      end
    end
    checks++;
    if (enable !== '0 || period !== 8'hFF || duty !== '0) begin
      errors++; $display("FAIL reset_outputs: got en=%h per=%h duty=%h expected 0/ff/0", enable, period, duty);
    end
  endtask

  // Edge 1 captures the event; the write lands SYNC+2 edges after that.
  task automatic test_latency_hold();
    int lat = 0;
    @(negedge clk);
    b_addr = 8'h03; b_data = 8'h80; b_event = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lat == 0 && duty[15:8] == 8'h80) lat = k;
    end
    b_event = 2'b00;
    repeat (SYNC + 4) @(negedge clk);
    model_apply(2'b11, 8'h03, 8'h80);
    checks++;
    if (SHADOW == 1'b0 && lat != SYNC + 3) begin
      errors++; $display("FAIL write_latency: got %0d edges expected %0d", lat, SYNC + 3);
    end
    b_addr = 8'h0E; #1;
    checks++;
    if (b_rdata !== 8'h10) begin
      errors++; $display("FAIL single_count: got STATUS %h expected 10", b_rdata);
    end
    b_addr = 8'h03; #1;
    checks++;
    if (b_rdata !== 8'h80) begin
      errors++; $display("FAIL duty1_read: got %h expected 80", b_rdata);
    end
  endtask

  task automatic test_skew();
    txn(2'b11, 8'h01, 8'h40, 8, 1'b1);
    b_addr = 8'h0E; #1;
    checks++;
    if (b_rdata !== {m_cnt[3:0], 3'b000, m_err} || m_cnt != 2) begin
      errors++; $display("FAIL skew_count: got %h expected %h", b_rdata, {m_cnt[3:0], 3'b000, m_err});
    end
    checks++;
    if (period !== m_period_out) begin
      errors++; $display("FAIL skew_period: got %h expected %h", period, m_period_out);
    end
  endtask

  task automatic test_ro_and_clear();
    txn(2'b11, 8'h0F, 8'h55, 8, 1'b0);
    b_addr = 8'h0F; #1;
    checks++;
    if (b_rdata !== 8'hA5) begin
      errors++; $display("FAIL id_after_write: got %h expected a5", b_rdata);
    end
    b_addr = 8'h0E; #1;
    checks++;
    if (b_rdata !== 8'h21) begin
      errors++; $display("FAIL err_set: got STATUS %h expected 21", b_rdata);
    end
    @(negedge clk);
    b_event = 2'b10;
    @(negedge clk);
    checks++;
    if (b_rdata[0] !== 1'b1) begin
      errors++; $display("FAIL err_during_read: got %b expected 1", b_rdata[0]);
    end
    repeat (7) @(negedge clk);
    b_event = 2'b00;
    repeat (SYNC + 4) @(negedge clk);
    model_apply(2'b10, 8'h0E, 8'h00);
    checks++;
    if (b_rdata !== 8'h20) begin
      errors++; $display("FAIL err_cleared: got STATUS %h expected 20", b_rdata);
    end
  endtask

  task automatic test_ctrl_bits();
    txn(2'b11, 8'h00, 8'hFF, 8, 1'b0);
    checks++;
    if (enable !== 4'hF) begin
      errors++; $display("FAIL ctrl_enable: got %h expected f", enable);
    end
    b_addr = 8'h00; #1;
    checks++;
    if (b_rdata !== 8'h0F) begin
      errors++; $display("FAIL ctrl_read: got %h expected 0f", b_rdata);
    end
    b_addr = 8'h0E; #1;
    checks++;
    if (b_rdata !== {m_cnt[3:0], 3'b000, m_err}) begin
      errors++; $display("FAIL ctrl_status: got %h expected %h", b_rdata, {m_cnt[3:0], 3'b000, m_err});
    end
  endtask

  task automatic test_wrap_and_reset_in_qual();
    do_reset();
    for (int i = 0; i < 16; i++) txn(2'b11, 8'h00, 8'($urandom), 8, 1'($urandom));
    b_addr = 8'h0E; #1;
    checks++;
    if (b_rdata[7:4] !== 4'h0) begin
      errors++; $display("FAIL count_wrap: got %h expected 0", b_rdata[7:4]);
    end
    txn(2'b11, 8'h02, 8'h33, 8, 1'b0);
    @(negedge clk);
    b_addr = 8'h01; b_data = 8'h77; b_event = 2'b11;
    repeat (SYNC + 1) @(negedge clk);
    rst = 1'b1; b_event = 2'b00;
    repeat (SYNC + 2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (SYNC + 4) @(negedge clk);
    checks++;
    if (enable !== '0 || period !== 8'hFF || duty !== '0) begin
      errors++; $display("FAIL reset_in_qual: got en=%h per=%h duty=%h expected 0/ff/0", enable, period, duty);
    end
    b_addr = 8'h0E; #1;
    checks++;
    if (b_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_in_qual_status: got %h expected 00", b_rdata);
    end
  endtask

  task automatic test_shadow();
    txn(2'b11, 8'h02, 8'h20, 8, 1'b0);
    repeat (10) @(negedge clk);
    period_end = 1'b1; #1;
    checks++;
    if (duty[7:0] !== (SHADOW ? 8'h00 : 8'h20)) begin
      errors++; $display("FAIL shadow_before: got %h expected %h", duty[7:0], SHADOW ? 8'h00 : 8'h20);
    end
    @(negedge clk);
    period_end = 1'b0;
    checks++;
    if (duty[7:0] !== 8'h20) begin
      errors++; $display("FAIL shadow_after: got %h expected 20", duty[7:0]);
    end
    m_period_out = m_period_sh;
    for (int n = 0; n < NUM_CH; n++) m_duty_out[n] = m_duty_sh[n];
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind, r, hold;
      logic [1:0] ev;
      logic [7:0] a;
      kind = $urandom_range(0, 3);
      r    = $urandom_range(0, 17);
      a    = (r < 16) ? 8'(r) : 8'($urandom_range(16, 255));
      ev   = (kind == 2) ? 2'b10 : 2'b11;
      hold = (kind == 3) ? 1 : $urandom_range(8, 14);
      txn(ev, a, 8'($urandom), hold, 1'($urandom));
      if ($urandom_range(0, 3) == 0) pulse_period_end();
      checks++;
      if (enable !== m_ctrl[NUM_CH-1:0] || period !== m_period_out) begin
        errors++; $display("FAIL rand_out %0d: got en=%h per=%h expected en=%h per=%h",
                           i, enable, period, m_ctrl[NUM_CH-1:0], m_period_out);
      end
      for (int n = 0; n < NUM_CH; n++) begin
        checks++;
        if (duty[8*n +: 8] !== m_duty_out[n]) begin
          errors++; $display("FAIL rand_duty %0d ch%0d: got %h expected %h", i, n, duty[8*n +: 8], m_duty_out[n]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        logic [7:0] ra;
        ra = (k == 0) ? a : 8'h0E;
        b_addr = ra; #1;
        checks++;
        if (b_rdata !== m_read(ra)) begin
          errors++; $display("FAIL rand_read %0d addr %h: got %h expected %h", i, ra, b_rdata, m_read(ra));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; b_addr = '0; b_data = '0; b_event = 2'b00; period_end = 1'b0;
    model_reset();
    test_reset();
    test_latency_hold();
    test_skew();
    test_ro_and_clear();
    test_ctrl_bits();
    test_wrap_and_reset_in_qual();
    test_shadow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Downstream consumer of the SPI slave's byte bus (address, write data, 2-bit event) inside the PWM controller.
- Brings the SPI-domain event into the system clock domain, qualifies it, and applies writes to the PWM register bank.
- Drives the combinational read-data mux back to the SPI slave, and implements read side effects (clear-on-read status).
- Outputs feed the PWM channel generators.

Parameters:
- NUM_CH, 4, number of PWM channels (1..8); duty registers occupy 0x02..0x02+NUM_CH-1.
- SYNC_STAGES, 2, flops per bit in the event synchronizer (>=2).
- PERIOD_RST, 8'hFF, reset value of PERIOD register.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- b_addr_i  in  8  register address from SPI slave (SPI domain, quasi-static).
- b_data_i  in  8  write data from SPI slave (SPI domain, quasi-static).
- b_event_i  in  2  00 idle, 10 read, 11 write (SPI domain, async).
- b_data_o  out  8  read data to SPI slave; combinational mux of b_addr_i over register bank.
- enable_o  out  NUM_CH  per-channel enable (CTRL[NUM_CH-1:0]).
- period_o  out  8  PWM period.
- duty_o  out  8*NUM_CH  duty per channel; channel n at [8n+7:8n].
- period_end_i  in  1  one-cycle pulse at PWM period wrap (used only with SPI_REG_SHADOW_EN).

Behaviour:
- Register map:
  - 0x00 CTRL RW, reset 0.
  - 0x01 PERIOD RW, reset PERIOD_RST.
  - 0x02+n DUTY[n] RW, reset 0.
  - 0x0E STATUS RO: [7:4] write count mod 16, [0] sticky error; reset 0.
  - 0x0F ID RO = 8'hA5.
  - Unmapped addresses read 8'h00.
- b_data_o: pure combinational from b_addr_i and current register values; no clk_i latency. The SPI slave samples it one SCK edge after the address byte.
- Event sync: each b_event_i bit passes through SYNC_STAGES flops; sync reset value 00.
- FSM (reset -> IDLE):
  - IDLE: synced event != 00 -> QUAL; record it as ev_prev.
  - QUAL: synced == 00 -> IDLE (aborted, no action). Synced != ev_prev -> stay in QUAL and update ev_prev, which filters 00->11 bit skew (01/10 transients). Synced == ev_prev -> ACT.
  - ACT (one cycle):
    - Write (11), mapped RW address: load b_data_i; STATUS[7:4] += 1 (wraps 15->0).
    - Write (11) to RO or unmapped address: no register change; set STATUS[0]; count unchanged.
    - Read (10) with address 0x0E: clear STATUS[0].
    - Other reads: no effect.
    - Then -> DONE.
  - DONE: wait for synced event == 00 -> IDLE. Exactly one action per transaction, however long nCS stays low.
- CTRL bits above NUM_CH-1 read as 0; writes to them are ignored and do not set the error bit.
- Write latency: register output changes on the clk_i edge ending ACT, i.e. SYNC_STAGES+2 cycles after b_event_i settles (immediate mode).
- rst_i high in any state: all registers to reset values, FSM to IDLE, sync flops cleared. An in-flight transaction is dropped.
- Precondition: clk_i >= 4x SCK; b_addr_i and b_data_i are stable whenever b_event_i != 00.

Optional Feature:
- SPI_REG_SHADOW_EN defined:
  - PERIOD and DUTY writes go to shadow registers.
  - period_o and duty_o update from the shadows on the cycle after period_end_i is high.
  - b_data_o returns the shadow values.
  - A write in the same cycle as period_end_i is applied on the following period_end_i.
  - CTRL remains immediate.
- Undefined: writes drive period_o and duty_o directly; period_end_i is unused.

Decomposition:
- Package spi_reg_pkg:
  - Address constants: ADDR_CTRL, ADDR_PERIOD, ADDR_DUTY0, ADDR_STATUS, ADDR_ID.
  - ID_VALUE 8'hA5.
  - EVENT_IDLE/EVENT_READ/EVENT_WRITE encodings.
  - FSM state typedef (IDLE, QUAL, ACT, DONE).
- Sub-module: event_sync, a parameterised SYNC_STAGES-deep, 2-bit synchronizer with synchronous reset.

Test Plan:
- Reset then read sweep: b_addr_i 0x00,0x01,0x0F,0x0E,0x20 -> b_data_o 0x00,0xFF,0xA5,0x00,0x00.
- Write 0x80 to 0x03 with event 11 held 20 cycles -> duty channel1 = 0x80 at SYNC_STAGES+2 cycles; STATUS = 0x10; exactly one count despite the long hold.
- Skewed event: drive 01 for 1 cycle then 11, writing 0x40 to 0x01 -> period_o = 0x40; no action on the 01 transient; count +1.
- Write 0x55 to 0x0F -> ID still 0xA5, STATUS[0] = 1. Read event at 0x0E -> b_data_o shows bit0 = 1 during the read; STATUS[0] = 0 afterwards.
- Sixteen writes to CTRL -> STATUS[7:4] wraps to 0. rst_i asserted during QUAL of a write -> no register change; all outputs at reset values.
- Shadow build: write duty 0x20 to 0x02, period_end_i pulsed 10 cycles later -> duty_o[7:0] stays 0 until the cycle after the pulse, then 0x20.
